ffd_piso_tx: RTL and testbench

Parallel-in, serial-out transmitter built on enabled D flip-flop stages. It accepts a parallel word through a valid/ready load handshake and shifts it out on a single line as one frame: start bit, data LSB-first, stop bit. One bit is sent per `enable` tick. It is the sending end of the serial link whose receiving side samples `D`/`enable` into flip-flops.

---
 rtl/ffd_piso_tx.sv | 89 ++++++++
 tb/tb_ffd_piso_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ffd_piso_tx.sv
// PISO serial transmitter: start bit, WIDTH data bits LSB-first, stop bit; one bit per enable tick.
// Start bit appears the cycle after load; load_ready stays low for the whole frame, so loads made while busy are ignored.
module ffd_piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]   bitcnt_q;
    logic            serial_q;
    logic            busy_q;
    logic            done_q;
    logic            ready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Capture ignores enable so a simultaneous tick is not spent on the start bit.
                    if (load_valid) begin
                        shreg_q  <= data_in;
                        state_q  <= START;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        serial_q <= 1'b0;
                    end
                end
                START: begin
                    if (enable) begin
                        serial_q <= shreg_q[0];
                        shreg_q  <= {1'b0, shreg_q[WIDTH-1:1]};
                        bitcnt_q <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        if (bitcnt_q != LAST_BIT) begin
                            serial_q <= shreg_q[0];
                            shreg_q  <= {1'b0, shreg_q[WIDTH-1:1]};
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end else begin
                            serial_q <= 1'b1;
                            state_q  <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_ffd_piso_tx.sv
// Directed bench for ffd_piso_tx with a frame-bit scoreboard and per-cycle handshake checks.
module tb_ffd_piso_tx;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] data_in = '0;
    logic             enable = 1'b0;
    logic             serial_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame bits queued at acceptance, popped each time a new bit should appear.
    logic q_exp[$];
    logic cur_bit  = 1'b1;
    logic m_active = 1'b0;
    logic m_adv    = 1'b0;
    logic m_done   = 1'b0;
    int   m_ticks  = 0;

    ffd_piso_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .enable     (enable),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_ticks  = 0;
            m_adv    = 1'b0;
            m_done   = 1'b0;
            q_exp.delete();
        end else begin
            m_adv  = 1'b0;
            m_done = 1'b0;
            if (!m_active) begin
                if (load_valid) begin
                    q_exp.push_back(1'b0);
                    for (int i = 0; i < WIDTH; i++) q_exp.push_back(data_in[i]);
                    q_exp.push_back(1'b1);
                    m_active = 1'b1;
                    m_ticks  = 0;
                    m_adv    = 1'b1;
                end
            end else if (enable) begin
                m_ticks++;
                if (m_ticks == WIDTH + 2) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_adv = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            cur_bit = 1'b1;
        end else begin
            if (m_adv) begin
                check("q_nonempty", q_exp.size() != 0, 1'b1);
                if (q_exp.size() != 0) cur_bit = q_exp.pop_front();
            end
            check("serial", serial_out, cur_bit);
            check("busy", busy, m_active);
            check("done", done, m_done);
            check("load_ready", load_ready, !m_active);
        end
    end

    task automatic load(input logic [WIDTH-1:0] w);
        @(negedge clk);
        load_valid = 1'b1;
        data_in    = w;
        @(negedge clk);
        load_valid = 1'b0;
        data_in    = ~w;
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = ((i % period) == (period - 1));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_serial"}, serial_out, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ready"}, load_ready, 1'b1);
    endtask

    initial begin
        // Power-on reset, asserted between clock edges.
        #1 reset = 1'b1;
        #1 check_reset_values("rst_init");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Single frame, enable held high, load coincides with enable.
        enable = 1'b1;
        load(4'b1011);
        run(8, 1);
        check("frame1_drained", q_exp.size() == 0, 1'b1);

        // Gated tick: one enable every fourth clock.
        enable = 1'b0;
        load(4'b0110);
        run(40, 4);
        check("gated_drained", q_exp.size() == 0, 1'b1);

        // Load attempt during SHIFT must be ignored.
        enable = 1'b1;
        load(4'b1111);
        run(2, 1);
        load_valid = 1'b1;
        data_in    = 4'b0000;
        @(negedge clk);
        load_valid = 1'b0;
        run(8, 1);
        check("ignored_drained", q_exp.size() == 0, 1'b1);

        // Back-to-back: second load presented in the done cycle.
        load(4'b1011);
        run(5, 1);
        @(negedge clk);
        check("b2b_done_cycle", done, 1'b1);
        check("b2b_ready_cycle", load_ready, 1'b1);
        load_valid = 1'b1;
        data_in    = 4'b0001;
        @(negedge clk);
        load_valid = 1'b0;
        check("b2b_start_bit", serial_out, 1'b0);
        run(8, 1);
        check("b2b_drained", q_exp.size() == 0, 1'b1);

        // Reset during the second data bit, then a clean frame.
        load(4'b1011);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_values("rst_mid");
        @(posedge clk);
        #2 reset = 1'b0;
        run(3, 1);
        load(4'b1010);
        run(8, 1);
        check("post_rst_drained", q_exp.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
